// File: rtl/fifo_flex_if.sv
// fifo_flex_if: producer/consumer bundle for fifo_flex.
//   master : the side driving requests (flush_i, wren_i/wdata_i, rden_i) and
//            observing data and status.
//   slave  : the FIFO itself.
//   Signals:
//     flush_i   synchronous flush request
//     wren_i    write request, wdata_i write data
//     rden_i    read/pop request, rdata_o read data
//     full_o, afull_o, empty_o, aempty_o   occupancy flags
//     count_o   occupancy 0..DEPTH
//     ovf_o, udf_o   sticky overflow / underflow status
interface fifo_flex_if #(
    parameter int DEPTH_LG2  = 4,
    parameter int DATA_WIDTH = 32
);
    logic                  flush_i;
    logic                  wren_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic                  rden_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  full_o;
    logic                  afull_o;
    logic                  empty_o;
    logic                  aempty_o;
    logic [DEPTH_LG2:0]    count_o;
    logic                  ovf_o;
    logic                  udf_o;

    modport master (
        output flush_i, wren_i, wdata_i, rden_i,
        input  rdata_o, full_o, afull_o, empty_o, aempty_o, count_o, ovf_o, udf_o
    );

    modport slave (
        input  flush_i, wren_i, wdata_i, rden_i,
        output rdata_o, full_o, afull_o, empty_o, aempty_o, count_o, ovf_o, udf_o
    );
endinterface

// File: rtl/fifo_flex.sv
// fifo_flex: single-clock synchronous FIFO with selectable first-word-fall-
// through read, occupancy count, programmable almost-full/almost-empty flags,
// synchronous flush and sticky overflow/underflow status.
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fifo_flex_if.slave (write side, read side, flags, count, status)
// Flags and count are registered and always describe the state after the
// most recent edge; request acceptance looks only at those registered flags.
module fifo_flex #(
    parameter int DEPTH_LG2  = 4,
    parameter int DATA_WIDTH = 32,
    parameter bit FWFT       = 1'b0,
    parameter int AFULL_TH   = (1 << DEPTH_LG2) - 1,
    parameter int AEMPTY_TH  = 1,
    parameter bit RST_MEM    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    fifo_flex_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LG2;
    localparam int AW    = DEPTH_LG2;
    localparam int PW    = DEPTH_LG2 + 1;

    localparam logic [PW-1:0] AFULL_V  = PW'(AFULL_TH);
    localparam logic [PW-1:0] AEMPTY_V = PW'(AEMPTY_TH);

    // Parameter sanity checks at elaboration.
    if (DEPTH_LG2 < 1) begin : g_bad_depth
        $error("fifo_flex: DEPTH_LG2 must be >= 1");
    end
    if ((AFULL_TH < 1) || (AFULL_TH > DEPTH)) begin : g_bad_afull
        $error("fifo_flex: AFULL_TH must be in 1..DEPTH");
    end
    if ((AEMPTY_TH < 0) || (AEMPTY_TH > DEPTH - 1)) begin : g_bad_aempty
        $error("fifo_flex: AEMPTY_TH must be in 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         count_q,  count_d;
    logic                  full_q,   full_d;
    logic                  afull_q,  afull_d;
    logic                  empty_q,  empty_d;
    logic                  aempty_q, aempty_d;
    logic                  ovf_q,    ovf_d;
    logic                  udf_q,    udf_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;

    logic wr_acc;
    logic rd_acc;
    logic mem_we;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        rdata_d  = rdata_q;
        mem_we   = 1'b0;

        wr_acc = bus.wren_i & ~full_q;
        rd_acc = bus.rden_i & ~empty_q;

        if (bus.flush_i) begin
            // Flush wins over everything; concurrent requests are neither
            // performed nor reported as overflow/underflow.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
            rdata_d  = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                mem_we   = 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                if (!FWFT) begin
                    rdata_d = mem_q[rd_ptr_q[AW-1:0]];
                end
            end
            if (bus.wren_i && full_q) begin
                ovf_d = 1'b1;
            end
            if (bus.rden_i && empty_q) begin
                udf_d = 1'b1;
            end
        end

        // Status is derived from the next pointers so every flag is a plain
        // register that already matches the post-edge occupancy.
        count_d  = wr_ptr_d - rd_ptr_d;
        empty_d  = (wr_ptr_d == rd_ptr_d);
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        afull_d  = (count_d >= AFULL_V);
        aempty_d = (count_d <= AEMPTY_V);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            empty_q  <= empty_d;
            aempty_q <= aempty_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            rdata_q  <= rdata_d;
        end
    end

    // Storage: only cleared by reset when RST_MEM is set; otherwise it stays
    // a reset-free array so it can map onto block RAM.
    if (RST_MEM) begin : g_mem_rst
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_q[i] <= '0;
                end
            end else if (mem_we) begin
                mem_q[wr_ptr_q[AW-1:0]] <= bus.wdata_i;
            end
        end
    end else begin : g_mem_norst
        always_ff @(posedge clk) begin
            if (mem_we) begin
                mem_q[wr_ptr_q[AW-1:0]] <= bus.wdata_i;
            end
        end
    end

    // Fall-through mode presents the head entry combinationally; it is only
    // meaningful while empty_o is low.
    if (FWFT) begin : g_rd_fwft
        assign bus.rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    end else begin : g_rd_reg
        assign bus.rdata_o = rdata_q;
    end

    assign bus.full_o   = full_q;
    assign bus.afull_o  = afull_q;
    assign bus.empty_o  = empty_q;
    assign bus.aempty_o = aempty_q;
    assign bus.count_o  = count_q;
    assign bus.ovf_o    = ovf_q;
    assign bus.udf_o    = udf_q;
endmodule

// File: tb/tb_fifo_flex.sv
// tb_fifo_flex: self-checking bench for fifo_flex (DEPTH 4, 8-bit data,
// AFULL_TH 3, AEMPTY_TH 1). u_dut0 is the registered-read variant driven from
// a vector table plus hand sequences; u_dut1 is the fall-through variant.
// Read data expectations come from a scoreboard queue fed on accepted writes.
module tb_fifo_flex;
    localparam bit N = 1'b0;
    localparam bit Y = 1'b1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_flex_if #(.DEPTH_LG2(2), .DATA_WIDTH(8)) bus0 ();
    fifo_flex_if #(.DEPTH_LG2(2), .DATA_WIDTH(8)) bus1 ();

    fifo_flex #(.DEPTH_LG2(2), .DATA_WIDTH(8), .FWFT(1'b0), .AFULL_TH(3),
                .AEMPTY_TH(1), .RST_MEM(1'b0))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    fifo_flex #(.DEPTH_LG2(2), .DATA_WIDTH(8), .FWFT(1'b1), .AFULL_TH(3),
                .AEMPTY_TH(1), .RST_MEM(1'b1))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    typedef struct {
        logic       fl;
        logic       wr;
        logic       rd;
        logic [7:0] wd;
        logic [2:0] cnt;
        logic       full;
        logic       afull;
        logic       empty;
        logic       aempty;
        logic       ovf;
        logic       udf;
    } vec_t;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] sb_q [$];
    logic [7:0] exp_rdata = 8'h00;

    vec_t tbl [0:16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input bit fl, input bit wr, input bit rd,
                                input logic [7:0] wd, input int cnt,
                                input bit full, input bit afull, input bit empty,
                                input bit aempty, input bit ovf, input bit udf);
        vec_t v;
        v.fl = fl; v.wr = wr; v.rd = rd; v.wd = wd; v.cnt = 3'(cnt);
        v.full = full; v.afull = afull; v.empty = empty; v.aempty = aempty;
        v.ovf = ovf; v.udf = udf;
        return v;
    endfunction

    // One cycle on u_dut0: drive, update the scoreboard from the pre-edge
    // occupancy, clock, then compare every output against the vector.
    task automatic apply_vec(input string tag, input vec_t v);
        bit wr_ok;
        bit rd_ok;
        wr_ok = v.wr && !v.fl && (sb_q.size() < 4);
        rd_ok = v.rd && !v.fl && (sb_q.size() > 0);
        bus0.flush_i = v.fl;
        bus0.wren_i  = v.wr;
        bus0.wdata_i = v.wd;
        bus0.rden_i  = v.rd;
        if (v.fl) begin
            sb_q.delete();
            exp_rdata = 8'h00;
        end else begin
            if (rd_ok) exp_rdata = sb_q.pop_front();
            if (wr_ok) sb_q.push_back(v.wd);
        end
        @(posedge clk);
        #1;
        bus0.flush_i = 1'b0;
        bus0.wren_i  = 1'b0;
        bus0.rden_i  = 1'b0;
        chk({tag, " count"},  32'(bus0.count_o),  32'(v.cnt));
        chk({tag, " full"},   32'(bus0.full_o),   32'(v.full));
        chk({tag, " afull"},  32'(bus0.afull_o),  32'(v.afull));
        chk({tag, " empty"},  32'(bus0.empty_o),  32'(v.empty));
        chk({tag, " aempty"}, 32'(bus0.aempty_o), 32'(v.aempty));
        chk({tag, " ovf"},    32'(bus0.ovf_o),    32'(v.ovf));
        chk({tag, " udf"},    32'(bus0.udf_o),    32'(v.udf));
        chk({tag, " rdata"},  32'(bus0.rdata_o),  32'(exp_rdata));
        $display("vec %s: fl=%0b wr=%0b wd=%02h rd=%0b -> count=%0d rdata=%02h",
                 tag, v.fl, v.wr, v.wd, v.rd, bus0.count_o, bus0.rdata_o);
    endtask

    task automatic drv1(input bit wr, input logic [7:0] wd, input bit rd);
        bus1.wren_i  = wr;
        bus1.wdata_i = wd;
        bus1.rden_i  = rd;
        @(posedge clk);
        #1;
        bus1.wren_i = 1'b0;
        bus1.rden_i = 1'b0;
        $display("fwft: wr=%0b wd=%02h rd=%0b -> count=%0d empty=%0b rdata=%02h",
                 wr, wd, rd, bus1.count_o, bus1.empty_o, bus1.rdata_o);
    endtask

    initial begin
        bus0.flush_i = 1'b0; bus0.wren_i = 1'b0; bus0.rden_i = 1'b0; bus0.wdata_i = 8'h00;
        bus1.flush_i = 1'b0; bus1.wren_i = 1'b0; bus1.rden_i = 1'b0; bus1.wdata_i = 8'h00;

        // Fill, overflow, drain
        tbl[0]  = mk(N, Y, N, 8'h01, 1, N, N, N, Y, N, N);
        tbl[1]  = mk(N, Y, N, 8'h02, 2, N, N, N, N, N, N);
        tbl[2]  = mk(N, Y, N, 8'h03, 3, N, Y, N, N, N, N);
        tbl[3]  = mk(N, Y, N, 8'h04, 4, Y, Y, N, N, N, N);
        tbl[4]  = mk(N, Y, N, 8'h05, 4, Y, Y, N, N, Y, N);
        tbl[5]  = mk(N, N, Y, 8'h00, 3, N, Y, N, N, Y, N);
        tbl[6]  = mk(N, N, Y, 8'h00, 2, N, N, N, N, Y, N);
        tbl[7]  = mk(N, N, Y, 8'h00, 1, N, N, N, Y, Y, N);
        tbl[8]  = mk(N, N, Y, 8'h00, 0, N, N, Y, Y, Y, N);
        // Underflow, then flush clears both sticky bits
        tbl[9]  = mk(N, N, Y, 8'h00, 0, N, N, Y, Y, Y, Y);
        tbl[10] = mk(Y, N, N, 8'h00, 0, N, N, Y, Y, N, N);
        // Flush with concurrent write+read at count 3
        tbl[11] = mk(N, Y, N, 8'h21, 1, N, N, N, Y, N, N);
        tbl[12] = mk(N, Y, N, 8'h22, 2, N, N, N, N, N, N);
        tbl[13] = mk(N, Y, N, 8'h23, 3, N, Y, N, N, N, N);
        tbl[14] = mk(Y, Y, Y, 8'h77, 0, N, N, Y, Y, N, N);
        tbl[15] = mk(N, Y, N, 8'h30, 1, N, N, N, Y, N, N);
        tbl[16] = mk(N, N, Y, 8'h00, 0, N, N, Y, Y, N, N);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst count",  32'(bus0.count_o),  32'd0);
        chk("rst empty",  32'(bus0.empty_o),  32'd1);
        chk("rst aempty", 32'(bus0.aempty_o), 32'd1);
        chk("rst full",   32'(bus0.full_o),   32'd0);
        chk("rst afull",  32'(bus0.afull_o),  32'd0);
        chk("rst rdata",  32'(bus0.rdata_o),  32'd0);
        chk("rst ovf",    32'(bus0.ovf_o),    32'd0);
        chk("rst udf",    32'(bus0.udf_o),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of traffic takes effect without a clock edge
        apply_vec("mid0", mk(N, Y, N, 8'h5A, 1, N, N, N, Y, N, N));
        apply_vec("mid1", mk(N, Y, N, 8'h6B, 2, N, N, N, N, N, N));
        apply_vec("mid2", mk(N, N, Y, 8'h00, 1, N, N, N, Y, N, N));
        rst_n = 1'b0;
        #2;
        chk("async rst count", 32'(bus0.count_o), 32'd0);
        chk("async rst empty", 32'(bus0.empty_o), 32'd1);
        chk("async rst rdata", 32'(bus0.rdata_o), 32'd0);
        sb_q.delete();
        exp_rdata = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        apply_vec("post0", mk(N, Y, N, 8'hA5, 1, N, N, N, Y, N, N));
        apply_vec("post1", mk(N, N, Y, 8'h00, 0, N, N, Y, Y, N, N));

        for (int i = 0; i < 17; i++) begin
            apply_vec($sformatf("tbl%0d", i), tbl[i]);
        end

        // Steady simultaneous read+write at count 2 across pointer wraps
        apply_vec("pre0", mk(N, Y, N, 8'hE0, 1, N, N, N, Y, N, N));
        apply_vec("pre1", mk(N, Y, N, 8'hE1, 2, N, N, N, N, N, N));
        for (int i = 0; i < 10; i++) begin
            apply_vec($sformatf("rw%0d", i), mk(N, Y, Y, 8'(8'h10 + i), 2, N, N, N, N, N, N));
        end
        apply_vec("dr0", mk(N, N, Y, 8'h00, 1, N, N, N, Y, N, N));
        apply_vec("dr1", mk(N, N, Y, 8'h00, 0, N, N, Y, Y, N, N));
        if (sb_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard residue: got %0d entries expected 0", sb_q.size());
        end

        // Fall-through variant
        drv1(Y, 8'h3C, N);
        chk("fwft empty after wr", 32'(bus1.empty_o), 32'd0);
        chk("fwft rdata head",     32'(bus1.rdata_o), 32'h3C);
        drv1(N, 8'h00, Y);
        chk("fwft empty after rd", 32'(bus1.empty_o), 32'd1);
        chk("fwft count after rd", 32'(bus1.count_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drv1(Y, 8'(8'h41 + i), N);
        end
        chk("fwft full",       32'(bus1.full_o),  32'd1);
        chk("fwft rdata 41",   32'(bus1.rdata_o), 32'h41);
        drv1(Y, 8'h55, Y);
        chk("fwft rw count",   32'(bus1.count_o), 32'd3);
        chk("fwft rw ovf",     32'(bus1.ovf_o),   32'd1);
        chk("fwft rw full",    32'(bus1.full_o),  32'd0);
        chk("fwft rdata 42",   32'(bus1.rdata_o), 32'h42);
        drv1(N, 8'h00, Y);
        chk("fwft rdata 43",   32'(bus1.rdata_o), 32'h43);
        drv1(N, 8'h00, Y);
        chk("fwft rdata 44",   32'(bus1.rdata_o), 32'h44);
        drv1(N, 8'h00, Y);
        chk("fwft drained",    32'(bus1.empty_o), 32'd1);
        chk("fwft udf clear",  32'(bus1.udf_o),   32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
